// File: rtl/trap_csr_unit_if.sv
// trap_csr_if: datapath <-> trap/CSR unit connection (retiring instruction info, CSR port, redirects)
interface trap_csr_if #(
    parameter int XLEN = 32
);
    logic            inst_valid;
    logic [XLEN-1:0] pc_cur;
    logic [31:0]     inst_raw;
    logic            ecall;
    logic            ill_inst;
    logic            mret;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            trap_taken;
    logic [XLEN-1:0] trap_pc;
    logic            mret_taken;
    logic [XLEN-1:0] mret_pc;
    modport master (
        output inst_valid, pc_cur, inst_raw, ecall, ill_inst, mret, csr_we, csr_addr, csr_wdata,
        input  csr_rdata, trap_taken, trap_pc, mret_taken, mret_pc
    );
    modport slave (
        input  inst_valid, pc_cur, inst_raw, ecall, ill_inst, mret, csr_we, csr_addr, csr_wdata,
        output csr_rdata, trap_taken, trap_pc, mret_taken, mret_pc
    );
endinterface

// File: rtl/trap_csr_unit.sv
// trap_csr_unit: machine-mode trap/CSR controller; prioritises exceptions over synchronised interrupts
module trap_csr_unit #(
    parameter int              XLEN        = 32,
    parameter int              NUM_IRQ     = 4,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input logic               clk,
    input logic               rst,
    input logic [NUM_IRQ-1:0] irq,
    trap_csr_if.slave         bus
);
    logic [NUM_IRQ-1:0] sync1, mip, mie, pend;
    logic               st_mie, st_mpie;
    logic [XLEN-1:0]    mtvec, mepc, mcause, mtval;
    logic               irq_hit;
    logic [3:0]         irq_idx;
    logic [4:0]         irq_code;
    logic               exc, intr, trap, do_mret, do_write;
    logic [XLEN-1:0]    base, cause;
    assign pend = mip & mie & {NUM_IRQ{st_mie}};
    // descending scan so the lowest pending index wins
    always_comb begin
        irq_hit = 1'b0;
        irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend[i]) begin
                irq_hit = 1'b1;
                irq_idx = 4'(i);
            end
    end
    assign irq_code = 5'd16 + {1'b0, irq_idx};
    assign exc      = bus.inst_valid & (bus.ill_inst | bus.ecall);
    assign intr     = bus.inst_valid & irq_hit & ~exc;
    assign trap     = exc | intr;
    assign do_mret  = bus.inst_valid & bus.mret & ~trap;
    assign do_write = bus.inst_valid & bus.csr_we & ~trap & ~bus.mret;
    assign base     = {mtvec[XLEN-1:2], 2'b00};
    assign cause    = bus.ill_inst ? XLEN'(2) : bus.ecall ? XLEN'(11) : {1'b1, {(XLEN-6){1'b0}}, irq_code};
    assign bus.trap_taken = trap;
    assign bus.trap_pc    = (intr & mtvec[0]) ? base + XLEN'({irq_code, 2'b00}) : base;
    assign bus.mret_taken = do_mret;
    assign bus.mret_pc    = mepc;
    always_comb begin
        case (bus.csr_addr)
            12'h300: bus.csr_rdata = XLEN'({st_mpie, 3'b000, st_mie, 3'b000});
            12'h304: bus.csr_rdata = XLEN'(mie);
            12'h305: bus.csr_rdata = mtvec;
            12'h341: bus.csr_rdata = mepc;
            12'h342: bus.csr_rdata = mcause;
            12'h343: bus.csr_rdata = mtval;
            12'h344: bus.csr_rdata = XLEN'(mip);
            default: bus.csr_rdata = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            mip     <= '0;
            mie     <= '0;
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
            mtvec   <= MTVEC_RESET;
            mepc    <= '0;
            mcause  <= '0;
            mtval   <= '0;
        end else begin
            sync1 <= irq;
            mip   <= sync1;
            if (trap) begin
                mepc    <= bus.pc_cur;
                mcause  <= cause;
                mtval   <= bus.ill_inst ? XLEN'(bus.inst_raw) : '0;
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
            end else if (do_mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (do_write) begin
                case (bus.csr_addr)
                    12'h300: begin
                        st_mie  <= bus.csr_wdata[3];
                        st_mpie <= bus.csr_wdata[7];
                    end
                    12'h304: mie    <= bus.csr_wdata[NUM_IRQ-1:0];
                    12'h305: mtvec  <= {bus.csr_wdata[XLEN-1:2], 1'b0, bus.csr_wdata[0]};
                    12'h341: mepc   <= {bus.csr_wdata[XLEN-1:2], 2'b00};
                    12'h342: mcause <= bus.csr_wdata;
                    12'h343: mtval  <= bus.csr_wdata;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trap_csr_unit.sv
// tb_trap_csr_unit: directed sequences, CSR vector table and random run against a reference model
module tb_trap_csr_unit;
    localparam int          XLEN        = 32;
    localparam int          NUM_IRQ     = 4;
    localparam logic [31:0] MTVEC_RESET = 32'h0000_0200;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NUM_IRQ-1:0] irq = '0;
    int                 n_cmp = 0;
    int                 n_bad = 0;
    trap_csr_if #(.XLEN(XLEN)) bus ();
    trap_csr_unit #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .MTVEC_RESET(MTVEC_RESET)) dut (
        .clk(clk), .rst(rst), .irq(irq), .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tab[12];
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
    logic [3:0]  m_mie, d1, d2;
    logic        m_ie, m_pie;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic idle();
        bus.inst_valid = 0; bus.ecall = 0; bus.ill_inst = 0; bus.mret = 0; bus.csr_we = 0;
        bus.csr_addr = '0; bus.csr_wdata = '0; bus.pc_cur = '0; bus.inst_raw = '0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic csr_wr(input logic [11:0] a, input logic [31:0] w);
        idle();
        bus.inst_valid = 1; bus.csr_we = 1; bus.csr_addr = a; bus.csr_wdata = w;
        tick();
        idle();
    endtask
    task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] e);
        idle();
        bus.csr_addr = a;
        #2;
        chk(nm, bus.csr_rdata, e);
        tick();
    endtask
    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return (m_pie ? 32'h80 : 32'h0) | (m_ie ? 32'h8 : 32'h0);
            12'h304: return {28'h0, m_mie};
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return {28'h0, d2};
            default: return 32'h0;
        endcase
    endfunction
    initial begin
        logic [11:0] addr_tab[8];
        addr_tab = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};
        tab[0]  = '{12'h304, 32'h0000_0000, 32'h0000_0000};
        tab[1]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_0088};
        tab[2]  = '{12'h300, 32'h0000_0000, 32'h0000_0000};
        tab[3]  = '{12'h304, 32'hFFFF_FFFF, 32'h0000_000F};
        tab[4]  = '{12'h304, 32'h0000_0000, 32'h0000_0000};
        tab[5]  = '{12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tab[6]  = '{12'h305, 32'h0000_0101, 32'h0000_0101};
        tab[7]  = '{12'h341, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        tab[8]  = '{12'h342, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tab[9]  = '{12'h343, 32'h1234_5678, 32'h1234_5678};
        tab[10] = '{12'h344, 32'hFFFF_FFFF, 32'h0000_0000};
        tab[11] = '{12'h7C0, 32'hFFFF_FFFF, 32'h0000_0000};
        idle();
        irq = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mtvec", 12'h305, MTVEC_RESET);
        rd("rst_mip", 12'h344, 32'h0);
        #2 rst = 1;
        bus.csr_addr = 12'h344;
        #1 chk("mip_0edge", bus.csr_rdata, 32'h0);
        tick();
        bus.inst_valid = 1;
        #1 chk("mip_1edge", bus.csr_rdata, 32'h0);
        chk("no_trap_1edge", 32'(bus.trap_taken), 32'h0);
        tick();
        #1 chk("mip_2edge", bus.csr_rdata, 32'h1);
        chk("no_trap_2edge", 32'(bus.trap_taken), 32'h0);
        tick();
        csr_wr(12'h304, 32'h1);
        csr_wr(12'h305, 32'h100);
        csr_wr(12'h300, 32'h8);
        bus.inst_valid = 1; bus.pc_cur = 32'h40;
        #1 chk("irq0_trap", 32'(bus.trap_taken), 32'h1);
        chk("irq0_pc", bus.trap_pc, 32'h100);
        tick();
        rd("irq0_mepc", 12'h341, 32'h40);
        rd("irq0_mcause", 12'h342, 32'h8000_0010);
        rd("irq0_mstatus", 12'h300, 32'h80);
        idle();
        bus.inst_valid = 1; bus.mret = 1;
        #1 chk("mret_taken", 32'(bus.mret_taken), 32'h1);
        chk("mret_pc", bus.mret_pc, 32'h40);
        tick();
        rd("mret_mstatus", 12'h300, 32'h88);
        bus.inst_valid = 1; bus.pc_cur = 32'h60; bus.csr_we = 1;
        bus.csr_addr = 12'h341; bus.csr_wdata = 32'h999;
        #1 chk("trapwr_trap", 32'(bus.trap_taken), 32'h1);
        chk("trapwr_prewrite", bus.csr_rdata, 32'h40);
        tick();
        rd("trapwr_mepc", 12'h341, 32'h60);
        rd("trapwr_mstatus", 12'h300, 32'h80);
        #2 rst = 0;
        #1 bus.csr_addr = 12'h300;
        #1 chk("midrst_mstatus", bus.csr_rdata, 32'h0);
        bus.csr_addr = 12'h341;
        #1 chk("midrst_mepc", bus.csr_rdata, 32'h0);
        bus.csr_addr = 12'h305;
        #1 chk("midrst_mtvec", bus.csr_rdata, MTVEC_RESET);
        bus.csr_addr = 12'h342;
        #1 chk("midrst_mcause", bus.csr_rdata, 32'h0);
        bus.csr_addr = 12'h344;
        #1 chk("midrst_mip", bus.csr_rdata, 32'h0);
        irq = 4'b0110;
        @(posedge clk);
        #3 rst = 1;
        tick();
        tick();
        csr_wr(12'h304, 32'h6);
        csr_wr(12'h305, 32'h101);
        csr_wr(12'h300, 32'h8);
        bus.inst_valid = 1; bus.pc_cur = 32'h80;
        #1 chk("vec_trap", 32'(bus.trap_taken), 32'h1);
        chk("vec_pc", bus.trap_pc, 32'h144);
        tick();
        rd("vec_mcause", 12'h342, 32'h8000_0011);
        csr_wr(12'h300, 32'h8);
        bus.inst_valid = 1; bus.ill_inst = 1; bus.ecall = 1;
        bus.inst_raw = 32'hFFFF_FFFF; bus.pc_cur = 32'h20;
        #1 chk("ill_trap", 32'(bus.trap_taken), 32'h1);
        chk("ill_pc", bus.trap_pc, 32'h100);
        tick();
        rd("ill_mcause", 12'h342, 32'h2);
        rd("ill_mtval", 12'h343, 32'hFFFF_FFFF);
        rd("ill_mepc", 12'h341, 32'h20);
        irq = '0;
        repeat (3) tick();
        for (int i = 0; i < 12; i++) begin
            csr_wr(tab[i].addr, tab[i].wdata);
            rd($sformatf("tab%0d", i), tab[i].addr, tab[i].exp);
        end
        rst = 0;
        tick();
        #2 rst = 1;
        m_mtvec = MTVEC_RESET; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_mie = 0; m_ie = 0; m_pie = 0; d1 = 0; d2 = 0;
        for (int n = 0; n < 500; n++) begin
            logic [3:0]  pend;
            logic        e_trap, e_irq, e_mret;
            logic [31:0] e_cause, e_pc;
            int          idx;
            if ($urandom_range(0, 7) == 0) irq = 4'($urandom);
            bus.inst_valid = $urandom_range(0, 3) != 0;
            bus.ill_inst = $urandom_range(0, 15) == 0;
            bus.ecall = $urandom_range(0, 15) == 0;
            bus.mret = $urandom_range(0, 7) == 0;
            bus.csr_we = 1'($urandom);
            bus.csr_addr = addr_tab[$urandom_range(0, 7)];
            bus.csr_wdata = $urandom;
            bus.pc_cur = $urandom;
            bus.inst_raw = $urandom;
            pend = m_ie ? (d2 & m_mie) : 4'h0;
            idx = -1;
            for (int k = 3; k >= 0; k--) if (pend[k]) idx = k;
            e_trap = 0; e_irq = 0; e_cause = 0;
            if (bus.inst_valid) begin
                if (bus.ill_inst) begin e_trap = 1; e_cause = 2; end
                else if (bus.ecall) begin e_trap = 1; e_cause = 11; end
                else if (idx >= 0) begin e_trap = 1; e_irq = 1; e_cause = 32'h8000_0000 + 32'(16 + idx); end
            end
            e_pc = m_mtvec & ~32'h3;
            if (e_irq && m_mtvec[1:0] == 2'b01) e_pc = e_pc + 32'(4 * (16 + idx));
            e_mret = bus.inst_valid && bus.mret && !e_trap;
            #1;
            chk($sformatf("rnd%0d_trap", n), 32'(bus.trap_taken), 32'(e_trap));
            if (e_trap) chk($sformatf("rnd%0d_tpc", n), bus.trap_pc, e_pc);
            chk($sformatf("rnd%0d_mret", n), 32'(bus.mret_taken), 32'(e_mret));
            chk($sformatf("rnd%0d_mpc", n), bus.mret_pc, m_mepc);
            chk($sformatf("rnd%0d_rd", n), bus.csr_rdata, m_read(bus.csr_addr));
            @(posedge clk);
            if (e_trap) begin
                m_mepc = bus.pc_cur; m_mcause = e_cause;
                m_mtval = bus.ill_inst ? bus.inst_raw : 32'h0;
                m_pie = m_ie; m_ie = 0;
            end else if (e_mret) begin
                m_ie = m_pie; m_pie = 1;
            end else if (bus.inst_valid && bus.csr_we) begin
                case (bus.csr_addr)
                    12'h300: begin m_ie = bus.csr_wdata[3]; m_pie = bus.csr_wdata[7]; end
                    12'h304: m_mie = bus.csr_wdata[3:0];
                    12'h305: m_mtvec = bus.csr_wdata & ~32'h2;
                    12'h341: m_mepc = bus.csr_wdata & ~32'h3;
                    12'h342: m_mcause = bus.csr_wdata;
                    12'h343: m_mtval = bus.csr_wdata;
                    default: ;
                endcase
            end
            d2 = d1;
            d1 = irq;
            #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
